// File: rtl/jt12_pkg.sv
// rtl/jt12_pkg.sv - shared constants, state/entry types and channel-code helpers for the key-on path
package jt12_pkg;
  localparam logic [7:0] KON_REG   = 8'h28;
  localparam int         SLOTS_6CH = 24;
  localparam int         SLOTS_3CH = 12;

  typedef enum logic {KON_IDLE, KON_HOLD} kon_state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] ch;
  } kon_entry_t;

  function automatic logic ch_valid(input logic [2:0] code, input int num_ch);
    if (num_ch == 3) return (code < 3'd3);
    return (code != 3'd3) && (code != 3'd7);
  endfunction

  // Six-channel parts skip code 3 between the two channel groups.
  function automatic logic [2:0] next_ch_inc(input logic [2:0] code, input int num_ch);
    if (num_ch == 3) return (code >= 3'd2) ? 3'd0 : code + 3'd1;
    if (code == 3'd2) return 3'd4;
    if (code >= 3'd6) return 3'd0;
    return code + 3'd1;
  endfunction
endpackage

// File: rtl/jt12_kon_fifo.sv
// rtl/jt12_kon_fifo.sv - circular buffer of pending key-on writes
module jt12_kon_fifo #(
  parameter int width = 7,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       push_data,
  output logic [width-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);
  localparam int PW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full buffer still lands.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/jt12_kon_ctrl.sv
// rtl/jt12_kon_ctrl.sv - slot rotation and key-on write scheduler holding each write for one rotation
module jt12_kon_ctrl #(
  parameter int num_ch     = 6,
  parameter int fifo_depth = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       clr_lost,
  output logic [1:0] next_op,
  output logic [2:0] next_ch,
  output logic [3:0] keyon_op,
  output logic [2:0] keyon_ch,
  output logic       up_keyon,
  output logic       busy,
  output logic       full,
  output logic       lost
);
  import jt12_pkg::*;

  localparam int              R         = (num_ch == 3) ? SLOTS_3CH : SLOTS_6CH;
  localparam int              HW        = $clog2(R);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(R - 1);

  kon_state_e                  state_q, state_d;
  logic [HW-1:0]               hold_q, hold_d;
  logic [1:0]                  op_q, op_d;
  logic [2:0]                  ch_q, ch_d;
  kon_entry_t                  act_q, act_d;
  logic                        lost_q, lost_d;
  logic                        wr_ok, push, pop;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(fifo_depth):0] fifo_count;
  kon_entry_t                  head, wr_entry;
  logic                        din_unused;

  assign din_unused = din[3];
  assign wr_entry   = '{op: din[7:4], ch: din[2:0]};
  assign wr_ok      = clk_en && wr && ch_valid(din[2:0], num_ch);

  jt12_kon_fifo #(.width(7), .depth(fifo_depth)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (wr_entry),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    op_d    = op_q;
    ch_d    = ch_q;
    act_d   = act_q;
    lost_d  = lost_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (clk_en) begin
      ch_d = next_ch_inc(ch_q, num_ch);
      if (ch_d == 3'd0) op_d = op_q + 2'd1;
      case (state_q)
        KON_IDLE: begin
          hold_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            push    = wr_ok;
            act_d   = head;
            state_d = KON_HOLD;
          end else if (wr_ok) begin
            act_d   = wr_entry;
            state_d = KON_HOLD;
          end
        end
        KON_HOLD: begin
          push = wr_ok;
          // Retire and reload on the same edge so back-to-back entries leave no gap.
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (!fifo_empty) begin
              pop   = 1'b1;
              act_d = head;
            end else begin
              state_d = KON_IDLE;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: state_d = KON_IDLE;
      endcase
      if (push && fifo_full && !pop) lost_d = 1'b1;
      else if (clr_lost)             lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= KON_IDLE;
      hold_q  <= '0;
      op_q    <= '0;
      ch_q    <= '0;
      act_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      op_q    <= op_d;
      ch_q    <= ch_d;
      act_q   <= act_d;
      lost_q  <= lost_d;
    end
  end

  assign next_op  = op_q;
  assign next_ch  = ch_q;
  assign keyon_op = act_q.op;
  assign keyon_ch = act_q.ch;
  assign up_keyon = (state_q == KON_HOLD);
  assign busy     = up_keyon || (fifo_count != '0);
  assign full     = fifo_full;
  assign lost     = lost_q;
endmodule

// File: tb/tb_jt12_kon_ctrl.sv
// tb/tb_jt12_kon_ctrl.sv - bench for jt12_kon_ctrl against a queue-based reference model
module tb_jt12_kon_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, clk_en, wr6, wr3, clr_lost;
  logic [7:0] din;

  logic [1:0] a_op, b_op;
  logic [2:0] a_ch, b_ch, a_kch, b_kch;
  logic [3:0] a_kop, b_kop;
  logic       a_up, b_up, a_busy, b_busy, a_full, b_full, a_lost, b_lost;

  jt12_kon_ctrl #(.num_ch(6), .fifo_depth(DEPTH)) dut6 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .wr(wr6), .din(din), .clr_lost(clr_lost),
    .next_op(a_op), .next_ch(a_ch), .keyon_op(a_kop), .keyon_ch(a_kch),
    .up_keyon(a_up), .busy(a_busy), .full(a_full), .lost(a_lost)
  );

  jt12_kon_ctrl #(.num_ch(3), .fifo_depth(DEPTH)) dut3 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .wr(wr3), .din(din), .clr_lost(clr_lost),
    .next_op(b_op), .next_ch(b_ch), .keyon_op(b_kop), .keyon_ch(b_kch),
    .up_keyon(b_up), .busy(b_busy), .full(b_full), .lost(b_lost)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int nch    = 6;

  int         m_pos;
  bit         m_active;
  int         m_left;
  logic [3:0] m_op;
  logic [2:0] m_ch;
  logic [6:0] m_q[$];
  bit         m_lost;

  function automatic bit m_valid(input logic [2:0] c);
    if (nch == 3) return c < 3'd3;
    return (c != 3'd3) && (c != 3'd7);
  endfunction

  function automatic logic [2:0] ch_at(input int i);
    if (nch == 3) return 3'(i);
    return (i < 3) ? 3'(i) : 3'(i + 1);
  endfunction

  task automatic m_reset();
    m_pos = 0; m_active = 0; m_left = 0; m_op = 0; m_ch = 0; m_lost = 0;
    m_q.delete();
  endtask

  task automatic m_load(input logic [6:0] e);
    m_active = 1; m_left = 4 * nch; m_op = e[6:3]; m_ch = e[2:0];
  endtask

  task automatic m_step(input bit w, input logic [7:0] d, input bit c);
    bit v, take, drop;
    logic [6:0] e;
    v = w && m_valid(d[2:0]); take = 0; drop = 0;
    m_pos = (m_pos + 1) % (4 * nch);
    if (!m_active) begin
      if (m_q.size() > 0) take = 1;
      else if (v) begin m_load({d[7:4], d[2:0]}); v = 0; end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_q.size() > 0) take = 1;
        else m_active = 0;
      end
    end
    if (take) begin e = m_q.pop_front(); m_load(e); end
    if (v) begin
      if (m_q.size() < DEPTH) m_q.push_back({d[7:4], d[2:0]});
      else drop = 1;
    end
    if (drop) m_lost = 1;
    else if (c) m_lost = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_up();   return (nch == 3) ? b_up   : a_up;   endfunction
  function automatic logic o_full(); return (nch == 3) ? b_full : a_full; endfunction
  function automatic logic o_lost(); return (nch == 3) ? b_lost : a_lost; endfunction
  function automatic logic o_busy(); return (nch == 3) ? b_busy : a_busy; endfunction

  task automatic check_all();
    int ri;
    ri = m_pos % nch;
    chk("next_ch",  (nch == 3) ? b_ch  : a_ch,  ch_at(ri));
    chk("next_op",  (nch == 3) ? b_op  : a_op,  8'(m_pos / nch));
    chk("keyon_op", (nch == 3) ? b_kop : a_kop, m_op);
    chk("keyon_ch", (nch == 3) ? b_kch : a_kch, m_ch);
    chk("up_keyon", o_up(),   m_active);
    chk("busy",     o_busy(), m_active || (m_q.size() != 0));
    chk("full",     o_full(), m_q.size() == DEPTH);
    chk("lost",     o_lost(), m_lost);
  endtask

  task automatic step(input bit en, input bit w, input logic [7:0] d, input bit c);
    clk_en = en; wr6 = w && (nch == 6); wr3 = w && (nch == 3); din = d; clr_lost = c;
    @(posedge clk);
    if (en) m_step(w, d, c);
    #1;
    clk_en = 0; wr6 = 0; wr3 = 0; clr_lost = 0;
    check_all();
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(3) != 0, $urandom_range(4) == 0, 8'($urandom), $urandom_range(15) == 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (m_active || m_q.size() != 0); i++) step(1, 0, 8'h00, 0);
    chk("drain_busy", o_busy(), 1'b0);
  endtask

  initial begin
    int cnt;
    logic [2:0] chs [5];
    chs[0] = 3'd0; chs[1] = 3'd1; chs[2] = 3'd2; chs[3] = 3'd4; chs[4] = 3'd5;
    rst = 1; clk_en = 0; wr6 = 0; wr3 = 0; din = 0; clr_lost = 0; nch = 6;
    m_reset();
    #2 check_all();
    @(posedge clk); #1 rst = 0;

    for (int i = 0; i < 30; i++) step(1, 0, 8'h00, 0);

    step(1, 1, 8'hF1, 0);
    chk("single_op", a_kop, 8'h0F);
    chk("single_ch", a_kch, 8'h01);
    cnt = 0;
    while (o_up() && cnt < 40) begin cnt++; step(1, 0, 8'h00, 0); end
    chk("single_up_len", 8'(cnt), 8'd24);
    chk("single_busy", o_busy(), 1'b0);

    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, {4'(i + 1), 1'b0, chs[i]}, 0);
      if (o_up()) cnt++;
    end
    chk("burst_full", o_full(), 1'b1);
    chk("burst_nolost", o_lost(), 1'b0);
    step(1, 1, 8'h86, 0);
    if (o_up()) cnt++;
    chk("burst_lost", o_lost(), 1'b1);
    for (int i = 0; i < 144; i++) begin
      step(1, 0, 8'h00, 0);
      if (o_up()) cnt++;
    end
    chk("burst_up_len", 8'(cnt), 8'd120);

    step(1, 0, 8'h00, 1);
    chk("clr_lost", o_lost(), 1'b0);
    step(1, 1, 8'hF3, 0);
    step(1, 1, 8'hF7, 0);
    chk("invalid_up", o_up(), 1'b0);
    chk("invalid_lost", o_lost(), 1'b0);

    for (int i = 0; i < 5; i++) step(1, 1, {4'(i + 9), 1'b0, chs[i]}, 0);
    for (int i = 0; i < 30 && m_left != 1; i++) step(1, 0, 8'h00, 0);
    step(1, 1, 8'h96, 0);
    chk("retire_full", o_full(), 1'b1);
    chk("retire_nolost", o_lost(), 1'b0);
    step(1, 1, 8'h35, 1);
    chk("clr_vs_drop", o_lost(), 1'b1);
    step(1, 0, 8'h00, 1);

    rand_steps(400);

    drain();
    step(1, 1, 8'h11, 0);
    step(1, 1, 8'h22, 0);
    step(1, 1, 8'h44, 0);
    rst = 1;
    #1;
    chk("rst_up", o_up(), 1'b0);
    chk("rst_busy", o_busy(), 1'b0);
    m_reset();
    @(posedge clk); #1 rst = 0;
    check_all();
    for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 0);

    rst = 1; nch = 3;
    m_reset();
    @(posedge clk); #1 rst = 0;
    check_all();
    for (int i = 0; i < 15; i++) step(1, 0, 8'h00, 0);
    step(1, 1, 8'hF4, 0);
    chk("inv3_up", o_up(), 1'b0);
    chk("inv3_lost", o_lost(), 1'b0);
    step(1, 1, 8'hF2, 0);
    cnt = 0;
    while (o_up() && cnt < 30) begin cnt++; step(1, 0, 8'h00, 0); end
    chk("ch3_up_len", 8'(cnt), 8'd12);
    rand_steps(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
